// File: rtl/fnd_scan_ctrl.sv
// rtl/fnd_scan_ctrl.sv - 4-digit FND scan scheduler with guard blanking and frame-aligned updates.
// Optional brightness dimming is enabled with `define FND_DIM_EN.
module fnd_scan_ctrl #(
    parameter int         DWELL_CYC = 5000,
    parameter int         BLANK_CYC = 50,
    parameter logic [7:0] SEG_BLANK = 8'hFF
) (
    input  logic        clk_wiz,
    input  logic        rst,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [31:0] upd_data,
    input  logic [3:0]  digit_en,
`ifdef FND_DIM_EN
    input  logic [3:0]  brightness,
`endif
    output logic [7:0]  seg_out,
    output logic [3:0]  dig_sel,
    output logic        frame_start
);

    localparam int CNT_MAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          en_q, en_d;
    logic [31:0]   shadow_q, shadow_d;
    logic [31:0]   pend_data_q, pend_data_d;
    logic          pend_q, pend_d;
    logic          upd_ready_q, upd_ready_d;
    logic [7:0]    seg_q, seg_d;
    logic [3:0]    dig_q, dig_d;
    logic          fs_q, fs_d;
    logic          lit;
`ifdef FND_DIM_EN
    logic [3:0]    phase_q, phase_d;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        en_d        = en_q;
        shadow_d    = shadow_q;
        pend_data_d = pend_data_q;
        pend_d      = pend_q;
        upd_ready_d = upd_ready_q;
        seg_d       = SEG_BLANK;
        dig_d       = 4'b0000;
        lit         = 1'b0;
`ifdef FND_DIM_EN
        phase_d     = phase_q + 4'd1;
`endif

        unique case (state_q)
            ST_BLANK: begin
                if (cnt_q == CW'(BLANK_CYC - 1)) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                    en_d    = digit_en[idx_q];
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SHOW: begin
                if (cnt_q == CW'(DWELL_CYC - 1)) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_BLANK;
        endcase

        // Output registers present the position held in the sequencer this cycle.
        fs_d = (state_q == ST_BLANK) && (idx_q == 2'd0) && (cnt_q == '0);
        lit  = (state_q == ST_SHOW) && en_q;
`ifdef FND_DIM_EN
        lit  = lit && ((brightness == 4'hF) || (phase_q < brightness));
`endif
        if (lit) begin
            dig_d = 4'b0001 << idx_q;
            seg_d = shadow_q[{idx_q, 3'b000} +: 8];
        end

        // fs_q marks the visible frame boundary; commit uses the flag as it stood then.
        if (fs_q && pend_q) begin
            shadow_d    = pend_data_q;
            pend_d      = 1'b0;
            upd_ready_d = 1'b1;
        end else if (upd_valid && upd_ready_q) begin
            pend_data_d = upd_data;
            pend_d      = 1'b1;
            upd_ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk_wiz or posedge rst) begin
        if (rst) begin
            state_q     <= ST_BLANK;
            idx_q       <= 2'd0;
            cnt_q       <= '0;
            en_q        <= 1'b0;
            shadow_q    <= {4{SEG_BLANK}};
            pend_data_q <= {4{SEG_BLANK}};
            pend_q      <= 1'b0;
            upd_ready_q <= 1'b1;
            seg_q       <= SEG_BLANK;
            dig_q       <= 4'b0000;
            fs_q        <= 1'b0;
`ifdef FND_DIM_EN
            phase_q     <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            en_q        <= en_d;
            shadow_q    <= shadow_d;
            pend_data_q <= pend_data_d;
            pend_q      <= pend_d;
            upd_ready_q <= upd_ready_d;
            seg_q       <= seg_d;
            dig_q       <= dig_d;
            fs_q        <= fs_d;
`ifdef FND_DIM_EN
            phase_q     <= phase_d;
`endif
        end
    end

    assign upd_ready   = upd_ready_q;
    assign seg_out     = seg_q;
    assign dig_sel     = dig_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb/tb_fnd_scan_ctrl.sv - self-checking bench for fnd_scan_ctrl against a slot/frame reference model.
module tb_fnd_scan_ctrl;

    localparam int DW    = 4;
    localparam int BL    = 2;
    localparam int SLOT  = DW + BL;
    localparam int FRAME = 4 * SLOT;

    logic        clk_wiz = 1'b0;
    logic        rst = 1'b1;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_data = 32'h0;
    logic [3:0]  digit_en = 4'hF;
    logic        upd_ready;
    logic [7:0]  seg_out;
    logic [3:0]  dig_sel;
    logic        frame_start;
`ifdef FND_DIM_EN
    logic [3:0]  brightness = 4'hF;
`endif

    fnd_scan_ctrl #(.DWELL_CYC(DW), .BLANK_CYC(BL), .SEG_BLANK(8'hFF)) dut (
        .clk_wiz     (clk_wiz),
        .rst         (rst),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_data    (upd_data),
        .digit_en    (digit_en),
`ifdef FND_DIM_EN
        .brightness  (brightness),
`endif
        .seg_out     (seg_out),
        .dig_sel     (dig_sel),
        .frame_start (frame_start)
    );

    always #5 clk_wiz = ~clk_wiz;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [7:0] m_shadow [4];
    logic [7:0] m_pend [4];
    bit         m_pend_v = 1'b0;
    bit         m_en = 1'b0;
    bit         m_on = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        cyc      = 0;
        m_pend_v = 1'b0;
        m_en     = 1'b0;
        m_on     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m_shadow[i] = 8'hFF;
            m_pend[i]   = 8'hFF;
        end
    endtask

    task automatic check_outputs();
        logic [7:0] es;
        logic [3:0] ed;
        logic       ef;
        int t, slot, w;
        es = 8'hFF;
        ed = 4'b0000;
        ef = 1'b0;
        if (cyc > 0) begin
            t    = (cyc - 1) % FRAME;
            slot = t / SLOT;
            w    = t % SLOT;
            ef   = (t == 0);
            if (w >= BL && m_en && m_on) begin
                ed = 4'(1 << slot);
                es = m_shadow[slot];
            end
        end
        chk("seg_out", 32'(seg_out), 32'(es));
        chk("dig_sel", 32'(dig_sel), 32'(ed));
        chk("frame_start", 32'(frame_start), 32'(ef));
        chk("upd_ready", 32'(upd_ready), 32'(!m_pend_v));
    endtask

    // Inputs are already driven for the coming edge; advance the model across it.
    task automatic step();
        int t, w;
        bit fs;
        check_outputs();
        t  = (cyc > 0) ? (cyc - 1) % FRAME : 0;
        w  = t % SLOT;
        fs = (cyc > 0) && (t == 0);
        if (fs && m_pend_v) begin
            for (int i = 0; i < 4; i++) m_shadow[i] = m_pend[i];
            m_pend_v = 1'b0;
        end else if (upd_valid && !m_pend_v) begin
            for (int i = 0; i < 4; i++) m_pend[i] = upd_data[8*i +: 8];
            m_pend_v = 1'b1;
        end
        if (cyc > 0 && w == 0) m_en = digit_en[t / SLOT];
`ifdef FND_DIM_EN
        m_on = (brightness == 4'hF) || ((cyc % 16) < int'(brightness));
`endif
        @(posedge clk_wiz);
        cyc++;
        @(negedge clk_wiz);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < FRAME + 1; i++) begin
            if (cyc > 0 && (cyc - 1) % FRAME == target) return;
            step();
        end
    endtask

    task automatic offer(input logic [31:0] d);
        upd_valid = 1'b1;
        upd_data  = d;
        step();
        upd_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge clk_wiz);
        @(negedge clk_wiz);
        chk("reset_seg", 32'(seg_out), 32'hFF);
        chk("reset_dig", 32'(dig_sel), 32'h0);
        chk("reset_rdy", 32'(upd_ready), 32'h1);
        rst = 1'b0;

        // Scan order with all digits enabled
        offer(32'h99A4F9C0);
        run(3 * FRAME);

        // Tear-free update offered mid-frame
        run_to(9);
        offer(32'h11223344);
        run(2 * FRAME);

        // Transfer accepted on the frame boundary itself
        run_to(0);
        offer(32'h55667788);
        run(2 * FRAME + 3);

        // Digit disable, changed mid-slot
        run_to(20);
        digit_en = 4'b1010;
        run(2 * FRAME);
        run_to(14);
        digit_en = 4'b0101;
        run(2 * FRAME);

        // Randomized traffic
        for (int i = 0; i < 6 * FRAME; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                upd_valid = 1'b1;
                upd_data  = $urandom;
            end else begin
                upd_valid = 1'b0;
            end
            if ($urandom_range(0, 9) == 0) digit_en = 4'($urandom);
            step();
        end
        upd_valid = 1'b0;
        digit_en  = 4'hF;

`ifdef FND_DIM_EN
        run_to(0);
        brightness = 4'd4;
        run(2 * FRAME);
        brightness = 4'd0;
        run(FRAME);
        brightness = 4'hF;
        run(FRAME);
`endif

        // Async reset during digit2 SHOW, with a pending update discarded
        run_to(8);
        offer($urandom);
        run_to(14);
        run(2);
        rst = 1'b1;
        #1;
        chk("async_seg", 32'(seg_out), 32'hFF);
        chk("async_dig", 32'(dig_sel), 32'h0);
        chk("async_fs", 32'(frame_start), 32'h0);
        chk("async_rdy", 32'(upd_ready), 32'h1);
        model_reset();
        @(negedge clk_wiz);
        @(negedge clk_wiz);
        rst = 1'b0;
        run(2 * FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fnd_scan_ctrl.md
Name: fnd_scan_ctrl

Overview:
Scan scheduler for the 4-digit FND. It time-multiplexes four 8-bit segment codes onto one shared segment bus and drives a one-hot digit select. A blanking guard interval between digits prevents ghosting. The displayed value is updated through a valid/ready port and loaded only at frame boundaries, so a frame never shows a mix of old and new digits. It sits between the counter/formatting logic and the FND pins, in the clk_wiz (5 MHz) domain.

Parameters:
DWELL_CYC, 5000, clk_wiz cycles each digit is driven (1 ms at 5 MHz); must be >= 1
BLANK_CYC, 50, guard cycles with all digits off before each digit; must be >= 1
SEG_BLANK, 8'hFF, segment code driven while blanked (active-low segments, all off)

Ports:
clk_wiz  in  1  system clock, 5 MHz
rst  in  1  asynchronous, active-high reset
upd_valid  in  1  new display data offered
upd_ready  out  1  controller can accept new data
upd_data  in  32  packed segment codes; [7:0] = digit0, [15:8] = digit1, [23:16] = digit2, [31:24] = digit3
digit_en  in  4  per-digit enable; 0 = digit kept dark in its slot
seg_out  out  8  shared segment bus
dig_sel  out  4  one-hot digit select, active-high; bit i = digit i
frame_start  out  1  one-cycle pulse on the first cycle of each frame

Behaviour:
- Clock and reset: reset rst, asynchronous, active-high; clock clk_wiz. All outputs are registered.
- Reset values: seg_out=SEG_BLANK, dig_sel=4'b0000, upd_ready=1, frame_start=0. Shadow and pending buffers are loaded with SEG_BLANK x4, pending flag=0, state=BLANK, idx=0, cnt=0.
- FSM states:
  - BLANK: dig_sel=0, seg_out=SEG_BLANK for exactly BLANK_CYC cycles, then go to SHOW.
  - SHOW: lasts exactly DWELL_CYC cycles. If digit_en[idx] is set, dig_sel=(1<<idx) and seg_out=shadow[idx]. If it is clear, dig_sel=0 and seg_out=SEG_BLANK. Then go to BLANK with idx=idx+1 mod 4 (3 wraps to 0).
- digit_en[idx] is sampled on the BLANK->SHOW transition and held for the whole slot.
- Disabled digits still consume their slot, so the frame period is constant: 4*(BLANK_CYC+DWELL_CYC) cycles.
- Frame boundary: the first cycle of BLANK with idx=0, including the first cycle after reset release. frame_start=1 on that cycle only.
- Update handshake:
  - A transfer occurs when upd_valid && upd_ready on a rising clk_wiz. upd_data is copied to pending, pending flag=1, and upd_ready drops the next cycle.
  - While upd_ready=0, upd_valid is ignored.
- Commit: at a frame boundary with pending flag=1 (as it stood at the start of that cycle), pending is copied to shadow and the flag is cleared. upd_ready=1 from the following cycle. The new codes first appear in the digit0 SHOW slot of that frame.
- Simultaneous events:
  - A transfer accepted in the same cycle as a frame boundary, with the flag previously 0, is not committed in that frame. It commits at the next boundary.
  - Changing digit_en mid-slot has no effect until the next slot.
- Reset mid-operation: outputs return to reset values immediately (asynchronous). Pending data is discarded and scanning restarts at BLANK idx=0.
- Counter: cnt must be wide enough for max(DWELL_CYC, BLANK_CYC)-1 and saturates at neither; it reloads on every state change.

Optional Feature:
FND_DIM_EN
- Defined:
  - Adds input port brightness[3:0] and an internal 4-bit free-running phase counter (reset 0, +1 per cycle, wraps).
  - During SHOW with digit_en[idx]=1, dig_sel is asserted only while phase < brightness; otherwise dig_sel=0 and seg_out=SEG_BLANK.
  - brightness=4'hF is treated as full on (always asserted); brightness=0 means dark.
  - brightness is sampled every cycle.
- Undefined: no brightness port and no phase counter; SHOW drives for the full dwell.

Test Plan:
All scenarios use DWELL_CYC=4, BLANK_CYC=2 (frame = 24 cycles).
- Scan order. Reset, then upd_data=32'h99_A4_F9_C0, digit_en=4'hF. -> After commit: dig_sel is 0000 x2, 0001 x4 with seg_out=C0, 0000 x2, 0010 x4 with seg_out=F9, ... then 1000 x4 with seg_out=99. frame_start pulses every 24 cycles.
- Tear-free update. Assert upd_valid with 32'h11223344 at the 10th cycle of a frame. -> upd_ready=0 from the next cycle. Digits 1-3 of the current frame keep their old codes. At the next frame_start the shadow updates; the digit0 slot shows 8'h44. upd_ready=1 one cycle after frame_start.
- Boundary collision. Accept upd_data on the frame_start cycle. -> The current frame shows the old codes; the new codes commit at the following frame_start.
- Digit disable. digit_en=4'b1010. -> Slots 0 and 2 have dig_sel=0 and seg_out=FF; slots 1 and 3 drive normally. Frame stays 24 cycles.
- Async reset mid-SHOW during digit2. -> In the same cycle seg_out=FF and dig_sel=0. After release, frame_start pulses on the first cycle, idx=0, and the display is blank (shadow reset).
- FND_DIM_EN, brightness=4. -> Each active 4-cycle dwell asserts dig_sel only in cycles where phase<4. brightness=0 gives dig_sel never set; brightness=15 gives the full dwell.
